// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU plus an iterative mul/div unit that
// stalls upstream through busy, and the execute/memory pipeline register.
module exec_stage #(
  parameter int XLEN = 32,
  parameter int RAW  = 5,
  parameter int SHW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_rs_d,
  input  logic [XLEN-1:0] in_rt_d,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  logic [RAW-1:0]  in_rd_a,
  input  logic            in_reg_write,
  input  logic            in_mem_write,
  input  logic            in_mem_read,
  input  logic            flush,
  output logic            busy,
  output logic            xm_valid,
  output logic [XLEN-1:0] xm_result,
  output logic [XLEN-1:0] xm_store_d,
  output logic [RAW-1:0]  xm_rd_a,
  output logic            xm_reg_write,
  output logic            xm_mem_write,
  output logic            xm_mem_read
);

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND = 4'd2,
                         OP_OR   = 4'd3,  OP_XOR  = 4'd4,  OP_SLL = 4'd5,
                         OP_SRL  = 4'd6,  OP_SRA  = 4'd7,  OP_SLT = 4'd8,
                         OP_SLTU = 4'd9,  OP_LUI  = 4'd10, OP_MUL = 4'd11,
                         OP_DIVU = 4'd12, OP_REMU = 4'd13;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_n;
  logic [SHW-1:0]  cnt;
  logic [3:0]      mc_op;
  logic [XLEN-1:0] mc_a;    // multiplicand (shifts left) or divisor
  logic [XLEN-1:0] mc_b;    // multiplier (shifts right) or dividend/quotient
  logic [XLEN-1:0] acc;     // product or partial remainder

  logic [XLEN-1:0] opb, alu_res, mc_res, result;
  logic [SHW-1:0]  sh;
  logic            is_mc, start;
  logic [XLEN:0]   div_tmp, div_sub;

  assign opb   = in_use_imm ? in_imm : in_rt_d;
  assign sh    = opb[SHW-1:0];
  assign is_mc = (in_op == OP_MUL) || (in_op == OP_DIVU) || (in_op == OP_REMU);
  assign start = (state == IDLE) && in_valid && is_mc && !flush;

  // Stall upstream while an iterative op is starting or running.
  always_comb begin
    busy = 1'b0;
    if (start) busy = 1'b1;
    else if (state == RUN && !flush) busy = 1'b1;
  end

  // Single-cycle ALU; reserved codes give 0.
  always_comb begin
    alu_res = '0;
    case (in_op)
      OP_ADD:  alu_res = in_rs_d + opb;
      OP_SUB:  alu_res = in_rs_d - opb;
      OP_AND:  alu_res = in_rs_d & opb;
      OP_OR:   alu_res = in_rs_d | opb;
      OP_XOR:  alu_res = in_rs_d ^ opb;
      OP_SLL:  alu_res = in_rs_d << sh;
      OP_SRL:  alu_res = in_rs_d >> sh;
      OP_SRA:  alu_res = XLEN'($signed(in_rs_d) >>> sh);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(in_rs_d) < $signed(opb)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, in_rs_d < opb};
      OP_LUI:  alu_res = opb << 16;
      default: alu_res = '0;
    endcase
  end

  // Restoring-division step: shift next dividend bit into the remainder.
  // With a zero divisor every step subtracts nothing, so the quotient
  // fills with ones and the remainder ends up equal to the dividend.
  always_comb begin
    div_tmp = {acc, mc_b[XLEN-1]};
    div_sub = div_tmp - {1'b0, mc_a};
  end

  assign mc_res = (mc_op == OP_DIVU) ? mc_b : acc;
  assign result = is_mc ? mc_res : alu_res;

  // FSM next state: IDLE -> RUN on start, RUN -> DONE after XLEN steps.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (flush) state_n = IDLE;
               else if (cnt == '0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register, iteration counter and iterative datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      mc_op <= '0;
      mc_a  <= '0;
      mc_b  <= '0;
      acc   <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        cnt   <= SHW'(XLEN-1);
        mc_op <= in_op;
        acc   <= '0;
        if (in_op == OP_MUL) begin
          mc_a <= in_rs_d;
          mc_b <= opb;
        end else begin
          mc_a <= opb;
          mc_b <= in_rs_d;
        end
      end else if (state == RUN && !flush) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        if (mc_op == OP_MUL) begin
          if (mc_b[0]) acc <= acc + mc_a;
          mc_a <= mc_a << 1;
          mc_b <= mc_b >> 1;
        end else if (!div_sub[XLEN]) begin
          acc  <= div_sub[XLEN-1:0];
          mc_b <= {mc_b[XLEN-2:0], 1'b1};
        end else begin
          acc  <= div_tmp[XLEN-1:0];
          mc_b <= {mc_b[XLEN-2:0], 1'b0};
        end
      end
    end
  end

  // Execute/memory register: bubble on flush, stall or empty slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xm_valid     <= 1'b0;
      xm_result    <= '0;
      xm_store_d   <= '0;
      xm_rd_a      <= '0;
      xm_reg_write <= 1'b0;
      xm_mem_write <= 1'b0;
      xm_mem_read  <= 1'b0;
    end else if (flush || !in_valid || busy) begin
      xm_valid     <= 1'b0;
      xm_rd_a      <= '0;
      xm_reg_write <= 1'b0;
      xm_mem_write <= 1'b0;
      xm_mem_read  <= 1'b0;
    end else begin
      xm_valid     <= 1'b1;
      xm_result    <= result;
      xm_store_d   <= in_rt_d;
      xm_rd_a      <= in_rd_a;
      xm_reg_write <= in_reg_write && (in_rd_a != '0);
      xm_mem_write <= in_mem_write;
      xm_mem_read  <= in_mem_read;
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage with hand-computed expectations.
module tb_exec_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_op;
  logic [31:0] in_rs_d, in_rt_d, in_imm;
  logic        in_use_imm;
  logic [4:0]  in_rd_a;
  logic        in_reg_write, in_mem_write, in_mem_read, flush;
  logic        busy, xm_valid;
  logic [31:0] xm_result, xm_store_d;
  logic [4:0]  xm_rd_a;
  logic        xm_reg_write, xm_mem_write, xm_mem_read;

  int total = 0;
  int bad   = 0;

  exec_stage #(.XLEN(32), .RAW(5), .SHW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_op(in_op),
    .in_rs_d(in_rs_d), .in_rt_d(in_rt_d), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_rd_a(in_rd_a),
    .in_reg_write(in_reg_write), .in_mem_write(in_mem_write),
    .in_mem_read(in_mem_read), .flush(flush), .busy(busy),
    .xm_valid(xm_valid), .xm_result(xm_result), .xm_store_d(xm_store_d),
    .xm_rd_a(xm_rd_a), .xm_reg_write(xm_reg_write),
    .xm_mem_write(xm_mem_write), .xm_mem_read(xm_mem_read)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
    in_valid = 1'b1; in_op = op; in_rs_d = a; in_rt_d = b;
    in_use_imm = 1'b0; in_rd_a = rd; in_reg_write = 1'b1;
  endtask

  // Present a multi-cycle op and wait (bounded) for its XM write.
  task automatic run_mc(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    bit got = 0;
    present(op, a, b, 5'd4);
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (xm_valid) got = 1;
    end
    chk({tag, "_done"}, {31'd0, got}, 32'd1);
    chk(tag, xm_result, exp);
  endtask

  logic [3:0]  t_op  [8];
  logic [31:0] t_exp [8];

  initial begin
    t_op[0] = 4'd1;  t_exp[0] = 32'h1234_5574;  // SUB
    t_op[1] = 4'd2;  t_exp[1] = 32'h0000_0000;  // AND
    t_op[2] = 4'd3;  t_exp[2] = 32'h1234_577C;  // OR
    t_op[3] = 4'd4;  t_exp[3] = 32'h1234_577C;  // XOR
    t_op[4] = 4'd5;  t_exp[4] = 32'h2345_6780;  // SLL by 4
    t_op[5] = 4'd6;  t_exp[5] = 32'h0123_4567;  // SRL by 4
    t_op[6] = 4'd10; t_exp[6] = 32'h0104_0000;  // LUI
    t_op[7] = 4'd14; t_exp[7] = 32'h0000_0000;  // reserved

    rst = 1'b0; flush = 1'b0; in_imm = '0; in_mem_write = 1'b0; in_mem_read = 1'b0;
    present(4'd0, 32'd5, 32'd3, 5'd1);
    tick(); tick();
    chk("rst_valid", {31'd0, xm_valid}, 32'd0);
    chk("rst_result", xm_result, 32'd0);
    chk("rst_rd", {27'd0, xm_rd_a}, 32'd0);
    chk("rst_rw", {31'd0, xm_reg_write}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    tick();
    chk("add_after_rst", xm_result, 32'd8);
    chk("add_after_rst_v", {31'd0, xm_valid}, 32'd1);

    present(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd3);
    tick();
    chk("add_wrap", xm_result, 32'd0);
    chk("add_wrap_rw", {31'd0, xm_reg_write}, 32'd1);
    present(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd0);
    tick();
    chk("add_rd0_rw", {31'd0, xm_reg_write}, 32'd0);

    // Immediate path plus store-data and control pass-through.
    present(4'd0, 32'd10, 32'hDEAD_BEEF, 5'd7);
    in_use_imm = 1'b1; in_imm = 32'd20; in_mem_write = 1'b1;
    tick();
    chk("add_imm", xm_result, 32'd30);
    chk("store_d", xm_store_d, 32'hDEAD_BEEF);
    chk("mem_write", {31'd0, xm_mem_write}, 32'd1);
    chk("rd_a", {27'd0, xm_rd_a}, 32'd7);
    in_mem_write = 1'b0;

    present(4'd7, 32'h8000_0000, 32'd4, 5'd2); tick();
    chk("sra", xm_result, 32'hF800_0000);
    present(4'd8, 32'hFFFF_FFFF, 32'd1, 5'd2); tick();
    chk("slt", xm_result, 32'd1);
    present(4'd9, 32'hFFFF_FFFF, 32'd1, 5'd2); tick();
    chk("sltu", xm_result, 32'd0);

    for (int i = 0; i < 8; i++) begin
      present(t_op[i], 32'h1234_5678, 32'h0000_0104, 5'd5);
      #1 chk($sformatf("busy_op%0d", t_op[i]), {31'd0, busy}, 32'd0);
      tick();
      chk($sformatf("op%0d", t_op[i]), xm_result, t_exp[i]);
    end
    chk("rsvd_rw", {31'd0, xm_reg_write}, 32'd1);

    // MUL 7*6 cycle-exact timing.
    present(4'd11, 32'd7, 32'd6, 5'd6);
    for (int c = 0; c <= 33; c++) begin
      #1 chk($sformatf("mul_busy_c%0d", c), {31'd0, busy}, (c <= 32) ? 32'd1 : 32'd0);
      tick();
      if (c + 1 <= 33) chk($sformatf("mul_bubble_e%0d", c + 1), {31'd0, xm_valid}, 32'd0);
    end
    chk("mul_res", xm_result, 32'd42);
    chk("mul_valid", {31'd0, xm_valid}, 32'd1);

    // Back-to-back multi-cycle ops.
    run_mc("divu_z", 4'd12, 32'd100, 32'd0, 32'hFFFF_FFFF);
    run_mc("remu_z", 4'd13, 32'd100, 32'd0, 32'd100);
    run_mc("divu",   4'd12, 32'd100, 32'd7, 32'd14);
    run_mc("remu",   4'd13, 32'd100, 32'd7, 32'd2);
    run_mc("mul_big", 4'd11, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F);

    // Flush abort mid-multiply.
    present(4'd11, 32'd7, 32'd6, 5'd6);
    for (int c = 0; c < 10; c++) tick();
    flush = 1'b1;
    #1 chk("flush_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("flush_valid", {31'd0, xm_valid}, 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("flush_valid2", {31'd0, xm_valid}, 32'd0);
    present(4'd0, 32'd1, 32'd2, 5'd1);
    #1 chk("flush_idle_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("flush_add", xm_result, 32'd3);

    // Reset abort mid-multiply.
    present(4'd11, 32'd7, 32'd6, 5'd6);
    for (int c = 0; c < 10; c++) tick();
    rst = 1'b0;
    #1 chk("rst_mid_result", xm_result, 32'd0);
    chk("rst_mid_valid", {31'd0, xm_valid}, 32'd0);
    tick();
    rst = 1'b1;
    present(4'd0, 32'd40, 32'd2, 5'd1);
    #1 chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("rst_mid_add", xm_result, 32'd42);
    chk("rst_mid_add_v", {31'd0, xm_valid}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exec_stage.md
# exec_stage

Execute stage of the five-stage pipeline. It consumes the operands, op code and control bits held in the decode/execute pipeline register and computes the ALU result. It owns the execute/memory pipeline register and drives the result back to the hazard unit as the execute-stage forwarding source. Multiply, divide and remainder run on an iterative one-bit-per-cycle unit that stalls upstream through `busy`.

## Interface
- `XLEN`, default 32: datapath width.
- `RAW`, default 5: register address width.
- `SHW`, default 5: shift-amount width, equal to log2(`XLEN`).

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset: asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `in_valid`  input  1  an instruction is present in the execute stage.
- `in_op`  input  4  ALU op code.
- `in_rs_d`  input  XLEN  operand A, already forwarded.
- `in_rt_d`  input  XLEN  operand B or store data, already forwarded.
- `in_imm`  input  XLEN  sign/zero-extended immediate.
- `in_use_imm`  input  1  selects `in_imm` as operand B.
- `in_rd_a`  input  RAW  destination register.
- `in_reg_write`, `in_mem_write`, `in_mem_read`  input  1 each  control bits bound for the memory/writeback stages.
- `flush`  input  1  kills the current execute instruction.
- `busy`  output  1  upstream holds the decode/execute register while this is high.
- `xm_valid`  output  1  execute/memory register holds a live instruction.
- `xm_result`  output  XLEN  ALU result; also the execute-stage forwarding data.
- `xm_store_d`  output  XLEN  registered `in_rt_d`.
- `xm_rd_a`  output  RAW  registered destination register.
- `xm_reg_write`, `xm_mem_write`, `xm_mem_read`  output  1 each  registered control bits.

## Operation
- Operand B is `in_use_imm ? in_imm : in_rt_d`. Operand A is `in_rs_d`.
- Single-cycle ops:
  - 0 ADD and 1 SUB, modulo 2^XLEN.
  - 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA, with shift amount `B[SHW-1:0]`.
  - 8 SLT (signed) and 9 SLTU, giving 0 or 1 zero-extended.
  - 10 LUI, giving `B << 16`.
  - 14 and 15 are reserved: result 0, controls pass through unchanged.
- Multi-cycle ops:
  - 11 MUL gives the low XLEN bits of A*B using shift-add.
  - 12 DIVU gives the unsigned quotient; 13 REMU gives the unsigned remainder. Both use restoring division.
  - Divide by zero: DIVU returns all ones and REMU returns A.
- FSM states: IDLE, RUN, DONE. A down-counter tracks the iterations.
  - IDLE -> RUN when `in_valid`, the op is multi-cycle and `!flush`. Operands are latched and the counter is set to XLEN-1.
  - RUN performs one bit-iteration per cycle. It goes to DONE on the edge where the counter is 0, which is XLEN iterations in total.
  - DONE -> IDLE unconditionally. On that edge the result is written to XM.
- `busy` is combinational:
  - high when state is IDLE, `in_valid`, the op is multi-cycle and `!flush`;
  - high when state is RUN and `!flush`;
  - low otherwise.
- XM register update, each edge:
  - `flush`, or `!in_valid`, or `busy`: load a bubble. A bubble is `xm_valid`=0, the three write/read bits 0 and `xm_rd_a`=0. `xm_result` and `xm_store_d` hold their values.
  - Otherwise load the live instruction: `xm_valid`=1, the result, store data, `rd_a` and controls.
- `xm_reg_write` is forced to 0 when `in_rd_a`==0.
- `flush` in RUN or DONE aborts to IDLE. No XM write occurs.

## Timing
- Reset (asynchronous assert):
  - State is IDLE and the counter is 0.
  - All XM outputs are 0.
  - `busy` follows its equation; it is 0 while `in_valid`=0.
- Single-cycle op: presented in cycle n, visible on the XM outputs after edge n+1. `busy` stays 0.
- Multi-cycle op first presented in cycle 0:
  - `busy`=1 in cycles 0 through XLEN, which is XLEN+1 cycles.
  - State is DONE and `busy`=0 in cycle XLEN+1.
  - The result is on the XM outputs after edge XLEN+2.
  - XM holds bubbles after edges 1 through XLEN+1.
- Upstream must present the same instruction, unchanged, for the whole multi-cycle sequence. DONE does not restart the FSM even though the op is still multi-cycle.
- Back-to-back: an instruction presented in the cycle after DONE is processed normally. That includes a second multi-cycle op, which restarts from IDLE.
- Reset deasserted mid-sequence: the FSM restarts from IDLE on the next presented op.

## Test plan
- Reset with `in_valid`=1, ADD, then release: all XM outputs are 0 during reset, then `xm_result` equals A+B one edge after release.
- ADD 0xFFFFFFFF+1 with `in_rd_a`=3: `xm_result`=0 and `xm_reg_write`=1. Repeat with `in_rd_a`=0: `xm_reg_write`=0.
- SRA A=0x80000000, B=4, then SLT A=-1, B=1, then SLTU with the same A and B: results are 0xF8000000, then 1, then 0.
- MUL 7*6 presented at cycle 0:
  - `busy` high for cycles 0–32 and low at cycle 33;
  - `xm_result`=42 and `xm_valid`=1 after edge 34;
  - `xm_valid`=0 after edges 1–33.
- DIVU and REMU with A=100, B=0: results are 0xFFFFFFFF and 100. Then DIVU 100/7 gives 14 and REMU 100/7 gives 2.
- Abort cases:
  - MUL, with `flush` pulsed at cycle 10: `busy` drops the same cycle, the state returns to IDLE, and `xm_valid` stays 0.
  - MUL, with `rst` asserted at cycle 10: all XM outputs go to 0 immediately. A following ADD completes in 1 cycle.
